dct_row_loader: RTL and testbench

- Front end of the 1-D DCT datapath: collects 8 serial 8-bit pixels into one row.
- Level-shifts each pixel by LEVEL_SHIFT and converts it to IEEE-754 single precision.
- Presents the 8 words in parallel to the Stage1 butterfly (adders/subtracters).
- Ping-pong buffered, so a new row fills while the previous row waits for downstream.

---
 rtl/dct_pkg.sv | 26 ++
 rtl/dct_row_loader_if.sv | 25 ++
 rtl/dct_row_loader_int_to_fp32.sv | 35 +++
 rtl/dct_row_loader.sv | 109 ++++++++++
 tb/tb_dct_row_loader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT datapath: row geometry and the
// IEEE-754 single-precision field layout used by every stage.
package dct_pkg;

  localparam int ROW_LEN   = 8;

  localparam int FP32_W    = 32;
  localparam int FP32_BIAS = 127;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0;

  // Field slices of a float32 word.
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MAN_MSB  = 22;
  localparam int FP32_MAN_LSB  = 0;
  localparam int FP32_EXP_W    = FP32_EXP_MSB - FP32_EXP_LSB + 1;
  localparam int FP32_MAN_W    = FP32_MAN_MSB - FP32_MAN_LSB + 1;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/dct_row_loader_if.sv
// Pixel-in / row-out bus of the DCT row loader. The master side feeds pixels
// and consumes rows; the slave side is the loader itself.
interface dct_row_loader_if #(
  parameter int PIX_W = 8
);
  import dct_pkg::*;

  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              row_valid;
  logic              row_ready;
  logic [FP32_W-1:0] D0, D1, D2, D3, D4, D5, D6, D7;

  modport master (
    output pix_valid, pix_data, row_ready,
    input  pix_ready, row_valid, D0, D1, D2, D3, D4, D5, D6, D7
  );

  modport slave (
    input  pix_valid, pix_data, row_ready,
    output pix_ready, row_valid, D0, D1, D2, D3, D4, D5, D6, D7
  );

endinterface

// File: rtl/dct_row_loader_int_to_fp32.sv
// Combinational signed-integer to float32 converter. Inputs are narrow
// enough (<= 24 significant bits) that the result is always exact.
module int_to_fp32
  import dct_pkg::*;
#(
  parameter int IN_W = 9
) (
  input  logic signed [IN_W-1:0]   val_i,
  output logic        [FP32_W-1:0] fp_o
);

  localparam int PW = $clog2(IN_W);

  logic [IN_W-1:0] mag;
  logic [PW-1:0]   msb_pos;
  fp32_t           fp;

  // Magnitude, leading-one position and left-justified mantissa.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    mag     = val_i[IN_W-1] ? $unsigned(-val_i) : $unsigned(val_i);
    msb_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag[i]) msb_pos = PW'(i);
    end
    fp.sign = val_i[IN_W-1];
    fp.exp  = FP32_EXP_W'(FP32_BIAS) + FP32_EXP_W'(msb_pos);
    // Shifting the magnitude right by its MSB index drops the hidden one
    // just above the mantissa field, leaving the lower bits left-justified.
    fp.man  = FP32_MAN_W'({mag, {FP32_MAN_W{1'b0}}} >> msb_pos);
    fp_o    = (mag == '0) ? FP32_ZERO : fp;
  end

endmodule

// File: rtl/dct_row_loader.sv
// DCT row loader: collects ROW_LEN serial pixels, level-shifts and converts
// each to float32, and presents a full row in parallel. Two row banks
// ping-pong so one row fills while the other waits for the consumer.
module dct_row_loader
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int LEVEL_SHIFT = 128
) (
  input logic             clk,
  input logic             reset,
  dct_row_loader_if.slave bus
);

  localparam int IN_W  = PIX_W + 1;
  localparam int IDX_W = $clog2(ROW_LEN);

  logic [FP32_W-1:0] bank_q [2][ROW_LEN];
  logic [1:0]        full_q, full_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;

  logic signed [IN_W-1:0] shifted;
  logic [FP32_W-1:0]      conv;
  logic                   accept;
  logic                   drain;
  logic                   last_col;

  // Ready depends only on registered state, never on row_ready.
  assign bus.pix_ready = reset & ~full_q[wr_bank_q];
  assign accept        = bus.pix_valid & bus.pix_ready;
  assign drain         = full_q[rd_bank_q] & bus.row_ready;
  assign last_col      = (wr_idx_q == IDX_W'(ROW_LEN - 1));

  // Level shift in PIX_W+1 signed bits; modular arithmetic keeps it exact
  // even when LEVEL_SHIFT equals 2^PIX_W.
  assign shifted = $signed({1'b0, bus.pix_data}) - $signed(IN_W'(LEVEL_SHIFT));

  int_to_fp32 #(.IN_W(IN_W)) u_conv (
    .val_i (shifted),
    .fp_o  (conv)
  );

  // Next-state logic for pointers and bank-full flags. Filling and draining
  // always touch different banks, so both updates can apply together.
  always_comb begin
    full_d    = full_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (accept) begin
      if (last_col) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      full_q    <= '0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Row storage: converted pixel written into the filling bank on accept.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the banks are reset because they drive D0..D7 directly and the
    // outputs must read zero, not X, straight out of reset.
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < ROW_LEN; k++) begin
          bank_q[b][k] <= FP32_ZERO;
        end
      end
    end else if (accept) begin
      bank_q[wr_bank_q][wr_idx_q] <= conv;
    end
  end

  assign bus.row_valid = full_q[rd_bank_q];
  assign bus.D0 = bank_q[rd_bank_q][0];
  assign bus.D1 = bank_q[rd_bank_q][1];
  assign bus.D2 = bank_q[rd_bank_q][2];
  assign bus.D3 = bank_q[rd_bank_q][3];
  assign bus.D4 = bank_q[rd_bank_q][4];
  assign bus.D5 = bank_q[rd_bank_q][5];
  assign bus.D6 = bank_q[rd_bank_q][6];
  assign bus.D7 = bank_q[rd_bank_q][7];

endmodule

// File: tb/tb_dct_row_loader.sv
// Testbench for dct_row_loader: directed and random pixel streams, with a
// queue of expected rows checked by an independent output monitor.
module tb_dct_row_loader;
  import dct_pkg::*;

  typedef logic [ROW_LEN-1:0][FP32_W-1:0] row_t;
  typedef logic [ROW_LEN-1:0][7:0]        pix_row_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   rows_seen = 0;
  row_t exp_q[$];
  int   hs_cyc[$];
  bit   rr_rand   = 1'b0;

  always #5 clk = ~clk;

  dct_row_loader_if #(.PIX_W(8)) bus ();

  dct_row_loader #(.PIX_W(8), .LEVEL_SHIFT(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference float32 via the simulator's double representation.
  function automatic logic [31:0] ref_fp32(input int v);
    real         r;
    logic [63:0] d;
    logic [31:0] f;
    int          e;
    if (v == 0) return 32'h0;
    r      = v;
    d      = $realtobits(r);
    e      = int'(d[62:52]) - 1023 + 127;
    f[31]  = d[63];
    f[30:23] = e[7:0];
    f[22:0]  = d[51:29];
    return f;
  endfunction

  function automatic row_t exp_row(input pix_row_t p);
    row_t r;
    for (int k = 0; k < ROW_LEN; k++) r[k] = ref_fp32(int'(p[k]) - 128);
    return r;
  endfunction

  function automatic row_t dut_row();
    row_t r;
    r[0] = bus.D0; r[1] = bus.D1; r[2] = bus.D2; r[3] = bus.D3;
    r[4] = bus.D4; r[5] = bus.D5; r[6] = bus.D6; r[7] = bus.D7;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random consumer backpressure, active only when rr_rand is set.
  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) bus.row_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: checks hold stability and pops expected rows on handshake.
  initial begin : monitor
    row_t cur, held, e;
    bit   held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.row_valid) begin
        cur = dut_row();
        if (held_v)
          for (int k = 0; k < ROW_LEN; k++) check($sformatf("hold_D%0d", k), cur[k], held[k]);
        if (bus.row_ready) begin
          hs_cyc.push_back(cyc);
          rows_seen++;
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL row_unexpected: got row D0=%08h expected no row", cur[0]);
          end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < ROW_LEN; k++)
              check($sformatf("row%0d_D%0d", rows_seen - 1, k), cur[k], e[k]);
          end
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pixel(input logic [7:0] p, output int waited);
    waited        = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = p;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) begin
        step();
        break;
      end
      waited++;
      if (waited > 2000) begin
        checks++;
        errors++;
        $display("FAIL pix_timeout: got no accept in %0d cycles expected accept", waited);
        step();
        break;
      end
    end
  endtask

  task automatic send_row(input pix_row_t p, input bit push, input bit gaps, output int maxwait);
    int w;
    maxwait = 0;
    if (push) exp_q.push_back(exp_row(p));
    for (int k = 0; k < ROW_LEN; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.pix_valid = 1'b0;
        step();
      end
      put_pixel(p[k], w);
      if (w > maxwait) maxwait = w;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d rows pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int       w, base, seen0;
    pix_row_t pr;
    row_t     er;

    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.row_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_row_valid", 32'(bus.row_valid), 32'd0);
    reset = 1'b1;
    step();
    check("post_rst_pix_ready", 32'(bus.pix_ready), 32'd1);
    check("post_rst_row_valid", 32'(bus.row_valid), 32'd0);
    er = dut_row();
    for (int k = 0; k < ROW_LEN; k++) check($sformatf("post_rst_D%0d", k), er[k], 32'h0);

    // Directed row with hand-computed float32 values.
    bus.row_ready = 1'b1;
    pr[0] = 8'd255; pr[1] = 8'd0;   pr[2] = 8'd128; pr[3] = 8'd129;
    pr[4] = 8'd127; pr[5] = 8'd192; pr[6] = 8'd64;  pr[7] = 8'd1;
    er[0] = 32'h42FE0000; er[1] = 32'hC3000000; er[2] = 32'h00000000; er[3] = 32'h3F800000;
    er[4] = 32'hBF800000; er[5] = 32'h42800000; er[6] = 32'hC2800000; er[7] = 32'hC2FE0000;
    exp_q.push_back(er);
    for (int k = 0; k < ROW_LEN; k++) begin
      if (k == ROW_LEN - 1) check("pre_last_row_valid", 32'(bus.row_valid), 32'd0);
      put_pixel(pr[k], w);
    end
    check("latency_row_valid", 32'(bus.row_valid), 32'd1);
    bus.pix_valid = 1'b0;
    wait_drain();

    // Continuous stream of three rows with the consumer always ready.
    base = hs_cyc.size();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'(((r * 8 + k) * 37 + 5) % 256);
      send_row(pr, 1'b1, 1'b0, w);
      check($sformatf("stream_wait_r%0d", r), 32'(w), 32'd0);
    end
    bus.pix_valid = 1'b0;
    wait_drain();
    repeat (2) step();
    check("stream_rows", 32'(hs_cyc.size() - base), 32'd3);
    if (hs_cyc.size() - base == 3) begin
      check("stream_gap0", 32'(hs_cyc[base + 1] - hs_cyc[base]), 32'd8);
      check("stream_gap1", 32'(hs_cyc[base + 2] - hs_cyc[base + 1]), 32'd8);
    end

    // Backpressure: both banks fill, then a single-cycle drain.
    bus.row_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'(200 - r * 50 + k * 3);
      send_row(pr, 1'b1, 1'b0, w);
      check($sformatf("bp_wait_r%0d", r), 32'(w), 32'd0);
    end
    check("bp_ready_low", 32'(bus.pix_ready), 32'd0);
    check("bp_row_valid", 32'(bus.row_valid), 32'd1);
    for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'(17 + k * 29);
    exp_q.push_back(exp_row(pr));
    bus.pix_valid = 1'b1;
    bus.pix_data  = pr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_ready_held%0d", i), 32'(bus.pix_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
    check("bp_ready_back", 32'(bus.pix_ready), 32'd1);
    check("bp_row1_valid", 32'(bus.row_valid), 32'd1);
    send_row(pr, 1'b0, 1'b0, w);
    check("bp_row2_wait", 32'(w), 32'd0);
    bus.pix_valid = 1'b0;
    bus.row_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a row discards the partial row.
    for (int k = 0; k < 5; k++) put_pixel(8'(240 + k), w);
    bus.pix_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("midrst_row_valid", 32'(bus.row_valid), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    er = dut_row();
    for (int k = 0; k < ROW_LEN; k++) check($sformatf("midrst_D%0d", k), er[k], 32'h0);
    for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'(10 + k * 31);
    send_row(pr, 1'b1, 1'b0, w);
    bus.pix_valid = 1'b0;
    wait_drain();

    // Random valid gaps and random backpressure over 100 rows.
    seen0   = rows_seen;
    rr_rand = 1'b1;
    for (int r = 0; r < 100; r++) begin
      for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'($urandom_range(0, 255));
      send_row(pr, 1'b1, 1'b1, w);
    end
    bus.pix_valid = 1'b0;
    rr_rand       = 1'b0;
    bus.row_ready = 1'b1;
    wait_drain();
    check("rand_rows", 32'(rows_seen - seen0), 32'd100);

    // Exhaustive conversion sweep over all pixel values.
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < ROW_LEN; k++) pr[k] = 8'(r * 8 + k);
      send_row(pr, 1'b1, 1'b0, w);
    end
    bus.pix_valid = 1'b0;
    wait_drain();
    repeat (3) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_row_valid", 32'(bus.row_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
